// File: rtl/ic_tester_pkg.sv
// Shared definitions for the IC tester run-control logic: FSM state encoding
// and the gate-select codes understood by the pattern checkers.
package ic_tester_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] GATE_AND     = 3'd0;
   localparam logic [2:0] GATE_OR      = 3'd1;
   localparam logic [2:0] GATE_NAND    = 3'd2;
   localparam logic [2:0] GATE_NOR     = 3'd3;
   localparam logic [2:0] GATE_XOR     = 3'd4;
   localparam logic [2:0] GATE_XNOR    = 3'd5;
   localparam logic [2:0] MAX_GATE_SEL = GATE_XNOR;

   function automatic logic gate_sel_valid(input logic [2:0] sel);
      return (sel <= MAX_GATE_SEL);
   endfunction

endpackage

// File: rtl/start_sync_edge.sv
// Two-flop synchroniser for the raw start button followed by a registered
// rising-edge detector producing a single-cycle start_pulse.
module start_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic start_pulse
);

   logic       sync1_reg;
   logic       sync2_reg;
   logic       prev_reg;
   logic [1:0] primed_reg;
   logic       rise;

   // primed_reg tracks when sync2_reg holds a genuine sample; until then the
   // previous level is treated as high so a button held through reset never fires.
   assign rise = primed_reg[1] & sync2_reg & ~prev_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg   <= 1'b0;
         sync2_reg   <= 1'b0;
         prev_reg    <= 1'b1;
         primed_reg  <= 2'b00;
         start_pulse <= 1'b0;
      end else begin
         sync1_reg   <= start;
         sync2_reg   <= sync1_reg;
         primed_reg  <= {primed_reg[0], 1'b1};
         prev_reg    <= primed_reg[1] ? sync2_reg : 1'b1;
         start_pulse <= rise;
      end
   end

endmodule

// File: rtl/ic_test_sequencer.sv
// Run-control FSM in front of the pattern checkers: clears the checker, runs it,
// latches its verdict (or a timeout / bad-select failure) for the display.
module ic_test_sequencer
   import ic_tester_pkg::*;
#(
   parameter int unsigned CLEAR_CYCLES   = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000,
   parameter int unsigned CNT_W          = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [2:0] ic_select,
   input  logic       pass_in,
   input  logic       fail_in,
   output logic       enable,
   output logic [2:0] gateSelect,
   output logic       busy,
   output logic       done,
   output logic       result_pass,
   output logic       result_fail,
   output logic       timeout,
   output logic       bad_select
);

   localparam longint unsigned CNT_MAX = (longint'(1) << CNT_W) - 1;
   localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   generate
      if (longint'(TIMEOUT_CYCLES) > CNT_MAX || longint'(CLEAR_CYCLES) > CNT_MAX) begin : g_cnt_too_narrow
         $error("ic_test_sequencer: CNT_W too narrow for CLEAR_CYCLES/TIMEOUT_CYCLES");
      end
      if (CLEAR_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_zero_cycles
         $error("ic_test_sequencer: CLEAR_CYCLES and TIMEOUT_CYCLES must be at least 1");
      end
   endgenerate

   logic start_pulse;

   start_sync_edge u_start_sync (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .start_pulse (start_pulse)
   );

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       gate_next;
   logic             pass_next, fail_next, timeout_next, bad_next;

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg + CNT_W'(1);
      gate_next    = gateSelect;
      pass_next    = result_pass;
      fail_next    = result_fail;
      timeout_next = timeout;
      bad_next     = bad_select;

      case (state_reg)
         ST_IDLE, ST_DONE: begin
            cnt_next = '0;
            if (start_pulse) begin
               gate_next    = ic_select;
               pass_next    = 1'b0;
               fail_next    = 1'b0;
               timeout_next = 1'b0;
               bad_next     = 1'b0;
               if (gate_sel_valid(ic_select)) begin
                  state_next = ST_CLEAR;
               end else begin
                  state_next = ST_DONE;
                  fail_next  = 1'b1;
                  bad_next   = 1'b1;
               end
            end
         end
         ST_CLEAR: begin
            if (cnt_reg == CLEAR_LAST) begin
               state_next = ST_RUN;
               cnt_next   = '0;
            end
         end
         ST_RUN: begin
            // A checker asserting both flags is treated as broken, hence fail.
            if (fail_in) begin
               state_next = ST_DONE;
               cnt_next   = '0;
               fail_next  = 1'b1;
            end else if (pass_in) begin
               state_next = ST_DONE;
               cnt_next   = '0;
               pass_next  = 1'b1;
            end else if (cnt_reg == TIMEOUT_LAST) begin
               state_next   = ST_DONE;
               cnt_next     = '0;
               fail_next    = 1'b1;
               timeout_next = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase

      if (abort) begin
         state_next   = ST_IDLE;
         cnt_next     = '0;
         gate_next    = gateSelect;
         pass_next    = 1'b0;
         fail_next    = 1'b0;
         timeout_next = 1'b0;
         bad_next     = 1'b0;
      end
   end

   // Outputs are decoded from the next state so they are glitch-free flops that
   // change on the same edge as the state itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         gateSelect  <= 3'd0;
         result_pass <= 1'b0;
         result_fail <= 1'b0;
         timeout     <= 1'b0;
         bad_select  <= 1'b0;
         enable      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         gateSelect  <= gate_next;
         result_pass <= pass_next;
         result_fail <= fail_next;
         timeout     <= timeout_next;
         bad_select  <= bad_next;
         enable      <= (state_next == ST_RUN);
         busy        <= (state_next == ST_CLEAR) || (state_next == ST_RUN);
         done        <= (state_next == ST_DONE);
      end
   end

endmodule
